// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned BCD_DIGIT_W = 4;

    // Smallest digit count d with 10^d > 2^width - 1.
    function automatic int unsigned min_digits(input int unsigned width);
        longint unsigned max_val;
        longint unsigned pow10;
        int unsigned     d;
        max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        pow10   = 64'd1;
        d       = 0;
        for (int i = 0; i < 20; i++) begin
            if (pow10 <= max_val) begin
                pow10 = pow10 * 64'd10;
                d     = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted_c
);

    assign adjusted_c = (digit >= BCD_DIGIT_W'(5)) ? (digit + BCD_DIGIT_W'(3)) : digit;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one bit per clock,
// with valid/ready handshakes on both sides.
module binary_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              binary,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned SR_W  = BCD_W + WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < 1 || DIGITS < min_digits(WIDTH)) begin : g_bad_params
        $error("binary_to_bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end

    state_t           state;
    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  sr_step_c;
    logic [BCD_W-1:0] adj_c;
    logic [CNT_W-1:0] cnt;
    logic             accept_c;
    logic             last_c;

    // Per-digit +3 correction on the BCD field of the shift register.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit      (sr[WIDTH + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .adjusted_c (adj_c[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    assign sr_step_c = SR_W'({adj_c, sr[WIDTH-1:0]} << 1);
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept_c  = in_valid && in_ready;
    assign last_c    = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            bcd       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        sr    <= SR_W'(binary);
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_step_c;
                    cnt <= cnt + CNT_W'(1);
                    if (last_c) begin
                        bcd       <= sr_step_c[SR_W-1 -: BCD_W];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Output handshake; a waiting input is taken in the same cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            sr    <= SR_W'(binary);
                            cnt   <= '0;
                            state <= SHIFT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Bench for binary_to_bcd_seq: a 4-bit/2-digit and an 8-bit/3-digit instance
// checked every cycle against a decimal-arithmetic model plus literal results.
module tb_binary_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        iv4, ir4, ov4, or4;
    logic [3:0]  b4;
    logic [7:0]  bcd4;
    logic        iv8, ir8, ov8, or8;
    logic [7:0]  b8;
    logic [11:0] bcd8;

    int n_vec = 0;
    int n_bad = 0;

    binary_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .binary(b4),
        .out_valid(ov4), .out_ready(or4), .bcd(bcd4)
    );

    binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .binary(b8),
        .out_valid(ov8), .out_ready(or8), .bcd(bcd8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int width_of(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic logic f_iv(input int i);
        return (i == 0) ? iv4 : iv8;
    endfunction

    function automatic logic f_or(input int i);
        return (i == 0) ? or4 : or8;
    endfunction

    function automatic logic f_ir(input int i);
        return (i == 0) ? ir4 : ir8;
    endfunction

    function automatic logic f_ov(input int i);
        return (i == 0) ? ov4 : ov8;
    endfunction

    function automatic logic [11:0] f_bcd(input int i);
        return (i == 0) ? {4'h0, bcd4} : bcd8;
    endfunction

    function automatic int f_bin(input int i);
        return (i == 0) ? int'(b4) : int'(b8);
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: cycles left until the result, pending value, held result.
    int          m_left  [2];
    logic        m_valid [2];
    logic [11:0] m_bcd   [2];
    int          m_val   [2];

    function automatic logic m_ready(input int i);
        return (m_left[i] == 0 && !m_valid[i]) || (m_valid[i] && f_or(i));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_left[i]  = 0;
                m_valid[i] = 1'b0;
                m_bcd[i]   = '0;
                m_val[i]   = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic acc;
                acc = f_iv(i) && m_ready(i);
                if (m_left[i] > 0) begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        m_valid[i] = 1'b1;
                        m_bcd[i]   = to_bcd(m_val[i]);
                    end
                end else if (m_valid[i] && f_or(i)) begin
                    m_valid[i] = 1'b0;
                end
                if (acc) begin
                    m_val[i]  = f_bin(i);
                    m_left[i] = width_of(i);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("in_ready[%0d]", i), 12'(f_ir(i)), 12'(m_ready(i)));
                check($sformatf("out_valid[%0d]", i), 12'(f_ov(i)), 12'(m_valid[i]));
                check($sformatf("bcd[%0d]", i), f_bcd(i), m_bcd[i]);
            end
        end
    end

    task automatic set_in(input int i, input logic v, input int val);
        if (i == 0) begin
            iv4 = v;
            b4  = 4'(val);
        end else begin
            iv8 = v;
            b8  = 8'(val);
        end
    endtask

    // One conversion; optionally disturbs binary/in_valid during SHIFT.
    task automatic do_conv(input int i, input int val, input logic [11:0] exp, input bit scramble);
        int cyc;
        int n;
        @(negedge clk);
        set_in(i, 1'b1, val);
        n = 0;
        while (!f_ir(i) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 12'(f_ir(i)), 12'd1);
        @(negedge clk);
        set_in(i, scramble, scramble ? (255 - val) : val);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            set_in(i, 1'b0, scramble ? 170 : val);
        end while (!f_ov(i) && cyc < 40);
        check("latency", 12'(cyc), 12'(width_of(i)));
        check("result", f_bcd(i), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d miscompares so far", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;
        logic [11:0] lit_exp [4];
        int          lit_val [4];
        lit_val = '{7, 9, 10, 15};
        lit_exp = '{12'h007, 12'h009, 12'h010, 12'h015};

        rst_n = 1'b0;
        iv4 = 1'b0; or4 = 1'b1; b4 = '0;
        iv8 = 1'b0; or8 = 1'b1; b8 = '0;
        #12;
        check("reset_in_ready4", 12'(ir4), 12'd1);
        check("reset_out_valid4", 12'(ov4), 12'd0);
        check("reset_bcd4", {4'h0, bcd4}, 12'h000);
        check("reset_in_ready8", 12'(ir8), 12'd1);
        check("reset_out_valid8", 12'(ov8), 12'd0);
        check("reset_bcd8", bcd8, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 16; v++) do_conv(0, v, to_bcd(v), v == 9);
        for (int k = 0; k < 4; k++) do_conv(0, lit_val[k], lit_exp[k], 1'b0);

        do_conv(1, 0, 12'h000, 1'b0);
        do_conv(1, 99, 12'h099, 1'b0);
        do_conv(1, 128, 12'h128, 1'b1);

        // Backpressure: result must freeze while out_ready is low.
        @(negedge clk);
        or8 = 1'b0;
        do_conv(1, 255, 12'h255, 1'b0);
        repeat (6) begin
            @(negedge clk);
            check("bp_out_valid", 12'(ov8), 12'd1);
            check("bp_bcd", bcd8, 12'h255);
            check("bp_in_ready", 12'(ir8), 12'd0);
        end
        or8 = 1'b1;
        @(negedge clk);
        check("drain_out_valid", 12'(ov8), 12'd0);
        check("drain_in_ready", 12'(ir8), 12'd1);

        // Back-to-back: second value taken in the DONE cycle of the first.
        iv8 = 1'b1;
        b8  = 8'd42;
        n = 0;
        while (!ir8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        b8 = 8'd137;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ov8 && cyc < 40);
        check("b2b_first_latency", 12'(cyc), 12'd8);
        check("b2b_first", bcd8, 12'h042);
        check("b2b_ready_in_done", 12'(ir8), 12'd1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            iv8 = 1'b0;
        end while (!ov8 && cyc < 40);
        check("b2b_spacing", 12'(cyc), 12'd9);
        check("b2b_second", bcd8, 12'h137);

        // Asynchronous reset two cycles into a conversion.
        @(negedge clk);
        iv8 = 1'b1;
        b8  = 8'd200;
        n = 0;
        while (!ir8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        iv8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 12'(ov8), 12'd0);
        check("rst_bcd", bcd8, 12'h000);
        check("rst_in_ready", 12'(ir8), 12'd1);
        #10;
        rst_n = 1'b1;
        do_conv(1, 5, 12'h005, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/binary_to_bcd_seq.md
# binary_to_bcd_seq

Parametrised, sequential successor to the combinational 4-bit binary-to-BCD converter. It converts a WIDTH-bit unsigned binary value to DIGITS packed BCD digits using the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock. A valid/ready handshake on the input and on the output lets it sit between a value source (switch or counter logic) and the seven-segment display drivers, with backpressure.

## Interface
Parameters:
- WIDTH, default 8: binary input width, ≥ 1.
- DIGITS, default 3: BCD output digits. Elaboration fails unless 10^DIGITS > 2^WIDTH − 1.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- in_valid  input  1  binary holds a value to convert.
- in_ready  output  1  block accepts input this cycle.
- binary  input  WIDTH  unsigned value; sampled only on input handshake.
- out_valid  output  1  bcd holds a finished result.
- out_ready  input  1  consumer takes result this cycle.
- bcd  output  4*DIGITS  packed BCD; digit 0 (units) at bcd[3:0], digit i at bcd[4i+3:4i].

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (any time, including mid-conversion): state IDLE, in_ready=1, out_valid=0, bcd=0, internal shift register and bit counter cleared. Any conversion in progress is discarded.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready only, never from in_valid.
- Input handshake (in_valid && in_ready at an edge):
  - Load binary into the low WIDTH bits of a (4*DIGITS + WIDTH)-bit shift register.
  - Clear the BCD field and the bit counter.
  - Go to SHIFT.
- SHIFT: each cycle, apply one double-dabble step:
  - Every BCD digit ≥ 5 gets +3 (4-bit, no carry out).
  - Then shift the whole register left by 1.
  - Increment the counter.
  - On the step where the counter reaches WIDTH−1 (the WIDTH-th shift), register the final BCD field into bcd and go to DONE.
- DONE: out_valid=1, and bcd is held stable until out_ready=1.
  - out_ready && !in_valid: go to IDLE; out_valid falls on the next cycle.
  - out_ready && in_valid: the output and input handshakes complete in the same cycle. Load the new value and go directly to SHIFT; out_valid falls on the next cycle.
- bcd keeps its last result in IDLE and SHIFT. It changes only on entry to DONE or on reset.
- While in SHIFT, in_ready=0; binary and in_valid are ignored.
- No digit ever exceeds 9. The top digit is 0 when the value fits in fewer digits.

## Timing
- Latency: input handshake at edge k gives out_valid=1 and a valid bcd after edge k+WIDTH (WIDTH cycles).
- With out_ready held high, throughput is one conversion per WIDTH+1 cycles (the accept-in-DONE path).
- With out_ready low, out_valid and bcd stay frozen indefinitely.
- WIDTH=1 edge case: a single SHIFT cycle, then DONE.

## Structure
- Package bcd_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - constant BCD_DIGIT_W = 4;
  - function min_digits(width), used for the elaboration check.
- Sub-module bcd_digit_adjust: 4-bit in, 4-bit out, performs the +3-if-≥5 step. It is instantiated DIGITS times via generate.
- Counter width: $clog2(WIDTH) bits, minimum 1.

## Test plan
- WIDTH=4, DIGITS=2: apply binary=0..15, one per handshake. Each result must match the reference model; e.g. 7→8'h07, 9→8'h09, 10→8'h10, 15→8'h15. out_valid must rise exactly 4 cycles after each accept.
- WIDTH=8, DIGITS=3: 0→12'h000, 99→12'h099, 128→12'h128, 255→12'h255.
- Backpressure: after 255 finishes, hold out_ready=0 for 6 cycles. Required: out_valid=1, bcd=12'h255, and in_ready=0 throughout. Then pulse out_ready with in_valid=0: out_valid=0 and in_ready=1 on the next cycle.
- Back-to-back: out_ready=1, in_valid=1 with 42 then 137. Required: the second value is accepted in the DONE cycle of the first, giving 12'h042 then 12'h137, results 9 cycles apart.
- Reset mid-conversion: deassert rst_n asynchronously two cycles into converting 200. Required: out_valid=0, bcd=0, and in_ready=1 immediately. After release, converting 5 yields 12'h005 with no residue from 200.
- Input stability: change binary while in SHIFT. The result must still reflect the value captured at the handshake.
